// File: rtl/pattern_display.sv
// Memory-game pattern playback: shows a snapshotted sequence of LED indices one at a
// time (one-hot), with a dark gap after each, then raises end_signal until restarted.
module pattern_display #(
    parameter int CNT_W      = 24,
    parameter int ON_CYCLES  = 12_000_000,
    parameter int OFF_CYCLES = 6_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] level,
    input  logic [2:0] pattern_1,
    input  logic [2:0] pattern_2,
    input  logic [2:0] pattern_3,
    input  logic [2:0] pattern_4,
    input  logic [2:0] pattern_5,
    input  logic [2:0] pattern_6,
    input  logic [2:0] pattern_7,
    input  logic [2:0] pattern_8,
    input  logic [2:0] pattern_9,
    input  logic [2:0] pattern_10,
    input  logic [2:0] pattern_11,
    input  logic [2:0] pattern_12,
    input  logic [2:0] pattern_13,
    input  logic [2:0] pattern_14,
    input  logic [2:0] pattern_15,
    input  logic [2:0] pattern_16,
    output logic [7:0] led,
    output logic [3:0] cur_index,
    output logic       busy,
    output logic       end_signal
);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       snap_q [16];
    logic [2:0]       snap_d [16];
    logic [2:0]       pat_in [16];
    logic [7:0]       led_q, led_d;
    logic [3:0]       cur_q, cur_d;
    logic             busy_q, busy_d;
    logic             end_q, end_d;

    // Last entry index for a level; out-of-range levels clamp to the nearest valid one.
    function automatic logic [3:0] last_of(input logic [2:0] lv);
        case (lv)
            3'd0, 3'd1: return 4'd7;
            3'd2:       return 4'd11;
            default:    return 4'd15;
        endcase
    endfunction

    assign pat_in = '{pattern_1,  pattern_2,  pattern_3,  pattern_4,
                      pattern_5,  pattern_6,  pattern_7,  pattern_8,
                      pattern_9,  pattern_10, pattern_11, pattern_12,
                      pattern_13, pattern_14, pattern_15, pattern_16};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_ON;
                        idx_d   = '0;
                        cnt_d   = '0;
                        snap_d  = pat_in;
                        last_d  = last_of(level);
                    end
                end
                S_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_OFF: begin
                    if (cnt_q == OFF_LAST) begin
                        cnt_d = '0;
                        if (idx_q == last_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ON;
                            idx_d   = idx_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they appear registered on the same edge.
        led_d = '0;
        if (state_d == S_ON) led_d[snap_d[idx_d]] = 1'b1;
        busy_d = (state_d == S_ON) || (state_d == S_OFF);
        end_d  = (state_d == S_DONE);
        cur_d  = (state_d == S_IDLE) ? 4'd0 : idx_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            snap_q  <= '{default: '0};
            led_q   <= '0;
            cur_q   <= '0;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            led_q   <= led_d;
            cur_q   <= cur_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
        end
    end

    assign led        = led_q;
    assign cur_index  = cur_q;
    assign busy       = busy_q;
    assign end_signal = end_q;

endmodule

// File: tb/tb_pattern_display.sv
// Bench for pattern_display: directed scenarios plus random traffic against a
// time-slot model of the playback (slot = elapsed/period, phase = elapsed%period).
module tb_pattern_display;

    localparam int ONC = 4;
    localparam int OFC = 2;
    localparam int P   = ONC + OFC;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] level = 3'd1;
    logic [2:0] pat [16];
    logic [7:0] led;
    logic [3:0] cur_index;
    logic       busy;
    logic       end_signal;

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 playing, 2 done
    int         m_mode = 0;
    int         m_t    = 0;
    int         m_len  = 8;
    logic [2:0] m_snap [16];

    wire [13:0] obs = {led, cur_index, busy, end_signal};

    always #5 clk = ~clk;

    pattern_display #(.CNT_W(24), .ON_CYCLES(ONC), .OFF_CYCLES(OFC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .level(level),
        .pattern_1(pat[0]),   .pattern_2(pat[1]),   .pattern_3(pat[2]),   .pattern_4(pat[3]),
        .pattern_5(pat[4]),   .pattern_6(pat[5]),   .pattern_7(pat[6]),   .pattern_8(pat[7]),
        .pattern_9(pat[8]),   .pattern_10(pat[9]),  .pattern_11(pat[10]), .pattern_12(pat[11]),
        .pattern_13(pat[12]), .pattern_14(pat[13]), .pattern_15(pat[14]), .pattern_16(pat[15]),
        .led(led), .cur_index(cur_index), .busy(busy), .end_signal(end_signal)
    );

    function automatic int len_of(input logic [2:0] lv);
        if (lv <= 3'd1) return 8;
        if (lv == 3'd2) return 12;
        return 16;
    endfunction

    function automatic logic [13:0] model_out();
        int slot, ph;
        logic [7:0] l;
        if (m_mode == 1) begin
            slot = m_t / P;
            ph   = m_t % P;
            l    = (ph < ONC) ? (8'd1 << m_snap[slot]) : 8'd0;
            return {l, 4'(slot), 2'b10};
        end
        if (m_mode == 2) return {8'd0, 4'(m_len - 1), 2'b01};
        return '0;
    endfunction

    // Advance one clock and apply the inputs seen at that edge to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst) m_mode = 0;
        else if (abort) m_mode = 0;
        else if (m_mode == 1) begin
            m_t++;
            if (m_t == m_len * P) m_mode = 2;
        end else if (start) begin
            m_mode = 1;
            m_t    = 0;
            m_snap = pat;
            m_len  = len_of(level);
        end
        #1;
    endtask

    task automatic rand_pat();
        for (int i = 0; i < 16; i++) pat[i] = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rand_pat();
        repeat (3) tick();
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs, 14'd0);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL idle_after_reset got=%h exp=%h", obs, 14'd0);
        end
    endtask

    task automatic test_walk();
        int rise;
        rise = -1;
        level = 3'd1;
        rand_pat();
        for (int i = 0; i < 8; i++) pat[i] = 3'(i);
        start = 1'b1;
        for (int c = 0; c < 56; c++) begin
            tick();
            start = 1'b0;
            if (end_signal === 1'b1 && rise < 0) rise = c;
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL walk c=%0d got=%h exp=%h", c, obs, model_out());
            end
        end
        checks++;
        if (rise !== 48) begin
            errors++;
            $display("FAIL walk_end_cycle got=%0d exp=48", rise);
        end
    endtask

    task automatic test_levels();
        logic [2:0] lvs [3];
        int         exp_fl [3];
        int         fl;
        logic [7:0] prev;
        lvs    = '{3'd3, 3'd0, 3'd7};
        exp_fl = '{16, 8, 16};
        for (int k = 0; k < 3; k++) begin
            level = lvs[k];
            if (k == 0) for (int i = 0; i < 16; i++) pat[i] = 3'd5;
            else rand_pat();
            fl    = 0;
            prev  = 8'd0;
            start = 1'b1;
            for (int c = 0; c < exp_fl[k] * P + 3; c++) begin
                tick();
                start = 1'b0;
                if (led !== 8'd0 && prev === 8'd0) fl++;
                prev = led;
                checks++;
                if (obs !== model_out()) begin
                    errors++;
                    $display("FAIL level%0d c=%0d got=%h exp=%h", lvs[k], c, obs, model_out());
                end
            end
            checks++;
            if (fl !== exp_fl[k]) begin
                errors++;
                $display("FAIL level%0d_flashes got=%0d exp=%0d", lvs[k], fl, exp_fl[k]);
            end
        end
    endtask

    task automatic test_snapshot();
        level = 3'd1;
        rand_pat();
        pat[1] = 3'd3;
        start = 1'b1;
        for (int c = 0; c < 52; c++) begin
            tick();
            start = (c == 19);
            if (c == 1) pat[1] = 3'd6;
            if (c == 6) begin
                checks++;
                if (led !== 8'h08) begin
                    errors++;
                    $display("FAIL snapshot_flash2 got=%h exp=%h", led, 8'h08);
                end
            end
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL snapshot c=%0d got=%h exp=%h", c, obs, model_out());
            end
        end
    endtask

    task automatic test_abort();
        level = 3'd2;
        rand_pat();
        start = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick();
            start = 1'b0;
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL abort_pre c=%0d got=%h exp=%h", c, obs, model_out());
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL abort_idle got=%h exp=%h", obs, 14'd0);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL abort_wins got=%h exp=%h", obs, 14'd0);
        end
    endtask

    task automatic test_rst_mid();
        level = 3'd3;
        rand_pat();
        start = 1'b1;
        repeat (20) begin
            tick();
            start = 1'b0;
        end
        #2;
        rst = 1'b0;
        m_mode = 0;
        #1;
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL rst_async got=%h exp=%h", obs, 14'd0);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        level = 3'd1;
        rand_pat();
        start = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            start = 1'b0;
            if (c == 0) begin
                checks++;
                if ({led, cur_index} !== {8'd1 << pat[0], 4'd0}) begin
                    errors++;
                    $display("FAIL rst_replay got=%h exp=%h", {led, cur_index}, {8'd1 << pat[0], 4'd0});
                end
            end
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL rst_replay c=%0d got=%h exp=%h", c, obs, model_out());
            end
        end
    endtask

    task automatic test_done_restart();
        checks++;
        if (end_signal !== 1'b1) begin
            errors++;
            $display("FAIL done_held got=%b exp=1", end_signal);
        end
        level = 3'd2;
        rand_pat();
        start = 1'b1;
        for (int c = 0; c < 76; c++) begin
            tick();
            start = 1'b0;
            if (c == 0) begin
                checks++;
                if ({end_signal, busy, cur_index, led} !== {2'b01, 4'd0, 8'd1 << pat[0]}) begin
                    errors++;
                    $display("FAIL done_restart got=%h exp=%h", {end_signal, busy, cur_index, led},
                             {2'b01, 4'd0, 8'd1 << pat[0]});
                end
            end
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL done_restart c=%0d got=%h exp=%h", c, obs, model_out());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 19) == 0);
            abort = ($urandom_range(0, 149) == 0);
            level = 3'($urandom_range(0, 7));
            rand_pat();
            tick();
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL random c=%0d got=%h exp=%h", c, obs, model_out());
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pat[i] = 3'd0;
        test_reset();
        test_walk();
        test_levels();
        test_snapshot();
        test_abort();
        test_rst_mid();
        test_done_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
